// File: rtl/tcb_lib_misalign_splitter_if.sv
// Bundle of the subordinate-side (byte address + size) and manager-side (aligned, byte-enable) TCB signals.
// The splitter uses the slave view; the surrounding CPU/memory environment uses the master view.
interface tcb_lib_misalign_splitter_if #(
    parameter int ADR = 32,
    parameter int DAT = 32
);
    localparam int BEN = DAT/8;

    // subordinate side: REFERENCE-style request, right-justified data
    logic           sub_vld;
    logic           sub_rdy;
    logic           sub_wen;
    logic           sub_ndn;
    logic [ADR-1:0] sub_adr;
    logic [1:0]     sub_siz;
    logic [DAT-1:0] sub_wdt;
    logic [DAT-1:0] sub_rdt;
    logic           sub_err;

    // manager side: MEMORY-mode request, lane-placed data
    logic           man_vld;
    logic           man_rdy;
    logic           man_wen;
    logic [ADR-1:0] man_adr;
    logic [BEN-1:0] man_ben;
    logic [DAT-1:0] man_wdt;
    logic [DAT-1:0] man_rdt;
    logic           man_err;

    modport slave (
        input  sub_vld, sub_wen, sub_ndn, sub_adr, sub_siz, sub_wdt,
        output sub_rdy, sub_rdt, sub_err,
        output man_vld, man_wen, man_adr, man_ben, man_wdt,
        input  man_rdy, man_rdt, man_err
    );

    modport master (
        output sub_vld, sub_wen, sub_ndn, sub_adr, sub_siz, sub_wdt,
        input  sub_rdy, sub_rdt, sub_err,
        input  man_vld, man_wen, man_adr, man_ben, man_wdt,
        output man_rdy, man_rdt, man_err
    );
endinterface

// File: rtl/tcb_lib_misalign_splitter.sv
// Turns byte-address/size TCB requests into aligned byte-enable beats, splitting bus-crossing
// accesses into two beats and merging the two read responses back into one.
module tcb_lib_misalign_splitter #(
    parameter int ADR = 32,
    parameter int DAT = 32,
    parameter int DLY = 1
)(
    input  logic clk,
    input  logic rst,
    tcb_lib_misalign_splitter_if.slave bus,
    output logic busy
);
    localparam int BEN = DAT/8;
    localparam int OFW = $clog2(BEN);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SECOND = 1'b1;

    localparam logic [1:0] K_SINGLE = 2'd0;
    localparam logic [1:0] K_BEAT0  = 2'd1;
    localparam logic [1:0] K_BEAT1  = 2'd2;

    localparam logic [OFW+1:0] ONE   = {{(OFW+1){1'b0}}, 1'b1};
    localparam logic [OFW+1:0] BEN_W = BEN[OFW+1:0];

    typedef struct packed {
        logic           vld;
        logic [1:0]     kind;
        logic [OFW-1:0] off;
        logic [1:0]     siz;
        logic           ndn;
    } rsp_t;

    logic [0:0]     state, state_nxt;
    logic [OFW-1:0] off;
    logic [OFW+1:0] len, fin;
    logic           spl, hs;
    logic [ADR-1:0] base;
    logic [BEN-1:0] ben;
    logic [DAT-1:0] wdt;

    // ------------------------------------------------------------ request side
    assign off  = bus.sub_adr[OFW-1:0];
    assign len  = ONE << bus.sub_siz;
    assign fin  = {2'b00, off} + len;
    assign spl  = fin > BEN_W;
    assign base = {bus.sub_adr[ADR-1:OFW], {OFW{1'b0}}};

    // Lane data is identical for both beats; only the enable mask differs, and
    // disabled lanes are zeroed so each beat carries just its own bytes.
    for (genvar l = 0; l < BEN; l++) begin : g_wlane
        logic [OFW-1:0] k, idx;
        logic           in_acc;
        assign k      = OFW'(l) - off;
        assign in_acc = {2'b00, k} < len;
        assign idx    = bus.sub_ndn ? (len[OFW-1:0] - OFW'(1) - k) : k;
        assign ben[l] = in_acc && ((state == SECOND) ? (OFW'(l) < off) : (OFW'(l) >= off));
        assign wdt[8*l +: 8] = ben[l] ? bus.sub_wdt[8*idx +: 8] : 8'h00;
    end

    assign bus.man_vld = (state == SECOND) | bus.sub_vld;
    assign bus.man_wen = bus.sub_wen;
    assign bus.man_adr = base + ((state == SECOND) ? ADR'(BEN) : '0);
    assign bus.man_ben = ben;
    assign bus.man_wdt = wdt;
    assign bus.sub_rdy = ((state == IDLE) && spl) ? 1'b0 : bus.man_rdy;

    assign hs   = bus.man_vld & bus.man_rdy;
    assign busy = (state == SECOND);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs && spl) state_nxt = SECOND;
            SECOND:  if (hs)        state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ------------------------------------------------------------ response tracking
    rsp_t           ent;
    rsp_t [DLY:1]   pipe;
    rsp_t           ex;
    logic [DAT-1:0] hold;
    logic           err_hold;

    always_comb begin
        ent      = '0;
        ent.vld  = hs;
        ent.kind = (state == SECOND) ? K_BEAT1 : (spl ? K_BEAT0 : K_SINGLE);
        ent.off  = off;
        ent.siz  = bus.sub_siz;
        ent.ndn  = bus.sub_ndn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[1] <= ent;
            for (int i = 2; i <= DLY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign ex = pipe[DLY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold     <= '0;
            err_hold <= 1'b0;
        end else if (ex.vld && ex.kind == K_BEAT0) begin
            hold     <= bus.man_rdt;
            err_hold <= bus.man_err;
        end
    end

    logic [DAT-1:0] src, rdt;
    logic [OFW+1:0] ex_len;
    logic           rsp_on;

    assign ex_len = ONE << ex.siz;

    // Beat 0 delivered the lanes at and above the offset; beat 1 the wrapped low lanes.
    for (genvar l = 0; l < BEN; l++) begin : g_src
        assign src[8*l +: 8] = (ex.kind == K_BEAT1 && OFW'(l) >= ex.off) ? hold[8*l +: 8]
                                                                          : bus.man_rdt[8*l +: 8];
    end

    for (genvar j = 0; j < BEN; j++) begin : g_rlane
        logic [OFW-1:0] kk, lane;
        assign kk   = ex.ndn ? (ex_len[OFW-1:0] - OFW'(1) - OFW'(j)) : OFW'(j);
        assign lane = ex.off + kk;
        assign rdt[8*j +: 8] = ({2'b00, OFW'(j)} < ex_len) ? src[8*lane +: 8] : 8'h00;
    end

    assign rsp_on      = ex.vld && (ex.kind != K_BEAT0);
    assign bus.sub_rdt = rsp_on ? rdt : '0;
    assign bus.sub_err = rsp_on & ((ex.kind == K_BEAT1) ? (err_hold | bus.man_err) : bus.man_err);

    assert property (@(posedge clk) disable iff (rst) bus.sub_vld |-> (32'(bus.sub_siz) <= OFW));

endmodule

// File: tb/tb_tcb_lib_misalign_splitter.sv
// Directed bench for the misalignment splitter at DAT=32, DLY=1.
module tb_tcb_lib_misalign_splitter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tcb_lib_misalign_splitter_if #(.ADR(32), .DAT(32)) bus ();

    tcb_lib_misalign_splitter #(.ADR(32), .DAT(32), .DLY(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic req(input logic wen, input logic ndn, input logic [31:0] adr,
                       input logic [1:0] siz, input logic [31:0] wdt);
        bus.sub_vld = 1'b1; bus.sub_wen = wen; bus.sub_ndn = ndn;
        bus.sub_adr = adr;  bus.sub_siz = siz; bus.sub_wdt = wdt;
    endtask

    task automatic idle_req();
        bus.sub_vld = 1'b0; bus.sub_wen = 1'b0; bus.sub_ndn = 1'b0;
        bus.sub_adr = '0;   bus.sub_siz = 2'd0; bus.sub_wdt = '0;
    endtask

    task automatic test_reset();
        idle_req();
        bus.man_rdy = 1'b1; bus.man_rdt = 32'hCAFEF00D; bus.man_err = 1'b1;
        rst = 1'b1;
        cyc(); cyc();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_chk++; if (bus.sub_rdt !== 32'h0) begin n_fail++; $display("FAIL reset_rdt got %h exp 0", bus.sub_rdt); end
        n_chk++; if (bus.sub_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.sub_err); end
        n_chk++; if (bus.man_vld !== 1'b0) begin n_fail++; $display("FAIL reset_man_vld got %b exp 0", bus.man_vld); end
        rst = 1'b0;
        bus.man_rdt = '0; bus.man_err = 1'b0;
        cyc();
    endtask

    task automatic test_single_read();
        req(1'b0, 1'b0, 32'h100, 2'd2, 32'h0);
        #1;
        n_chk++; if (bus.man_adr !== 32'h100) begin n_fail++; $display("FAIL single_adr got %h exp 100", bus.man_adr); end
        n_chk++; if (bus.man_ben !== 4'b1111) begin n_fail++; $display("FAIL single_ben got %b exp 1111", bus.man_ben); end
        n_chk++; if (bus.sub_rdy !== 1'b1) begin n_fail++; $display("FAIL single_rdy got %b exp 1", bus.sub_rdy); end
        n_chk++; if (bus.man_vld !== 1'b1) begin n_fail++; $display("FAIL single_man_vld got %b exp 1", bus.man_vld); end
        cyc();
        idle_req(); bus.man_rdt = 32'hDDCCBBAA; #1;
        n_chk++; if (bus.sub_rdt !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL single_rdt got %h exp ddccbbaa", bus.sub_rdt); end
        n_chk++; if (bus.sub_err !== 1'b0) begin n_fail++; $display("FAIL single_err got %b exp 0", bus.sub_err); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got %b exp 0", busy); end
        cyc(); bus.man_rdt = '0;
    endtask

    task automatic test_split_write();
        req(1'b1, 1'b0, 32'h103, 2'd2, 32'h44332211);
        #1;
        n_chk++; if (bus.sub_rdy !== 1'b0) begin n_fail++; $display("FAIL sw_b0_rdy got %b exp 0", bus.sub_rdy); end
        n_chk++; if (bus.man_adr !== 32'h100) begin n_fail++; $display("FAIL sw_b0_adr got %h exp 100", bus.man_adr); end
        n_chk++; if (bus.man_ben !== 4'b1000) begin n_fail++; $display("FAIL sw_b0_ben got %b exp 1000", bus.man_ben); end
        n_chk++; if (bus.man_wdt !== 32'h11000000) begin n_fail++; $display("FAIL sw_b0_wdt got %h exp 11000000", bus.man_wdt); end
        n_chk++; if (bus.man_wen !== 1'b1) begin n_fail++; $display("FAIL sw_wen got %b exp 1", bus.man_wen); end
        cyc(); #1;
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sw_busy got %b exp 1", busy); end
        n_chk++; if (bus.man_adr !== 32'h104) begin n_fail++; $display("FAIL sw_b1_adr got %h exp 104", bus.man_adr); end
        n_chk++; if (bus.man_ben !== 4'b0111) begin n_fail++; $display("FAIL sw_b1_ben got %b exp 0111", bus.man_ben); end
        n_chk++; if (bus.man_wdt !== 32'h00443322) begin n_fail++; $display("FAIL sw_b1_wdt got %h exp 00443322", bus.man_wdt); end
        n_chk++; if (bus.sub_rdy !== 1'b1) begin n_fail++; $display("FAIL sw_b1_rdy got %b exp 1", bus.sub_rdy); end
        cyc();
        idle_req(); #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sw_done_busy got %b exp 0", busy); end
        cyc();
    endtask

    task automatic test_split_read_stall();
        req(1'b0, 1'b0, 32'h103, 2'd2, 32'h0);
        cyc();
        bus.man_rdy = 1'b0; bus.man_rdt = 32'hAA000000; #1;
        n_chk++; if (bus.sub_rdt !== 32'h0) begin n_fail++; $display("FAIL sr_b0_rdt got %h exp 0", bus.sub_rdt); end
        n_chk++; if (bus.sub_rdy !== 1'b0) begin n_fail++; $display("FAIL sr_stall_rdy got %b exp 0", bus.sub_rdy); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus.man_rdt = 32'h12345678;
            n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sr_stall_busy%0d got %b exp 1", i, busy); end
        end
        bus.man_rdy = 1'b1;
        cyc();
        idle_req(); bus.man_rdt = 32'h00DDCCBB; #1;
        n_chk++; if (bus.sub_rdt !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL sr_rdt got %h exp ddccbbaa", bus.sub_rdt); end
        n_chk++; if (bus.sub_err !== 1'b0) begin n_fail++; $display("FAIL sr_err got %b exp 0", bus.sub_err); end
        cyc(); bus.man_rdt = '0;
    endtask

    task automatic test_split_err();
        req(1'b0, 1'b0, 32'h103, 2'd2, 32'h0);
        cyc();
        bus.man_rdt = 32'hAA000000; bus.man_err = 1'b1; #1;
        n_chk++; if (bus.sub_err !== 1'b0) begin n_fail++; $display("FAIL se_b0_err got %b exp 0", bus.sub_err); end
        cyc();
        idle_req(); bus.man_rdt = 32'h00DDCCBB; bus.man_err = 1'b0; #1;
        n_chk++; if (bus.sub_err !== 1'b1) begin n_fail++; $display("FAIL se_err got %b exp 1", bus.sub_err); end
        n_chk++; if (bus.sub_rdt !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL se_rdt got %h exp ddccbbaa", bus.sub_rdt); end
        cyc(); bus.man_rdt = '0;
    endtask

    task automatic test_big_endian();
        req(1'b1, 1'b1, 32'h3, 2'd1, 32'h1122);
        #1;
        n_chk++; if (bus.man_adr !== 32'h0) begin n_fail++; $display("FAIL be_b0_adr got %h exp 0", bus.man_adr); end
        n_chk++; if (bus.man_ben !== 4'b1000) begin n_fail++; $display("FAIL be_b0_ben got %b exp 1000", bus.man_ben); end
        n_chk++; if (bus.man_wdt !== 32'h11000000) begin n_fail++; $display("FAIL be_b0_wdt got %h exp 11000000", bus.man_wdt); end
        cyc(); #1;
        n_chk++; if (bus.man_adr !== 32'h4) begin n_fail++; $display("FAIL be_b1_adr got %h exp 4", bus.man_adr); end
        n_chk++; if (bus.man_ben !== 4'b0001) begin n_fail++; $display("FAIL be_b1_ben got %b exp 0001", bus.man_ben); end
        n_chk++; if (bus.man_wdt !== 32'h00000022) begin n_fail++; $display("FAIL be_b1_wdt got %h exp 00000022", bus.man_wdt); end
        cyc();
        // unsplit big-endian halfword read at offset 1
        req(1'b0, 1'b1, 32'h1, 2'd1, 32'h0);
        #1;
        n_chk++; if (bus.man_ben !== 4'b0110) begin n_fail++; $display("FAIL be_rd_ben got %b exp 0110", bus.man_ben); end
        cyc();
        idle_req(); bus.man_rdt = 32'h00BBAA00; #1;
        n_chk++; if (bus.sub_rdt !== 32'h0000AABB) begin n_fail++; $display("FAIL be_rd_rdt got %h exp 0000aabb", bus.sub_rdt); end
        cyc(); bus.man_rdt = '0;
    endtask

    task automatic test_wrap();
        req(1'b0, 1'b0, 32'hFFFFFFFE, 2'd2, 32'h0);
        #1;
        n_chk++; if (bus.man_adr !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wr_b0_adr got %h exp fffffffc", bus.man_adr); end
        n_chk++; if (bus.man_ben !== 4'b1100) begin n_fail++; $display("FAIL wr_b0_ben got %b exp 1100", bus.man_ben); end
        cyc();
        bus.man_rdt = 32'hBBAA0000; #1;
        n_chk++; if (bus.man_adr !== 32'h00000000) begin n_fail++; $display("FAIL wr_b1_adr got %h exp 0", bus.man_adr); end
        n_chk++; if (bus.man_ben !== 4'b0011) begin n_fail++; $display("FAIL wr_b1_ben got %b exp 0011", bus.man_ben); end
        cyc();
        idle_req(); bus.man_rdt = 32'h0000DDCC; #1;
        n_chk++; if (bus.sub_rdt !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL wr_rdt got %h exp ddccbbaa", bus.sub_rdt); end
        cyc(); bus.man_rdt = '0;
    endtask

    task automatic test_back_to_back();
        req(1'b0, 1'b0, 32'h201, 2'd0, 32'h0);
        cyc();
        req(1'b0, 1'b0, 32'h206, 2'd1, 32'h0);
        bus.man_rdt = 32'h00005A00; #1;
        n_chk++; if (bus.sub_rdt !== 32'h0000005A) begin n_fail++; $display("FAIL b2b_a_rdt got %h exp 5a", bus.sub_rdt); end
        n_chk++; if (bus.man_ben !== 4'b1100) begin n_fail++; $display("FAIL b2b_b_ben got %b exp 1100", bus.man_ben); end
        n_chk++; if (bus.sub_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_b_rdy got %b exp 1", bus.sub_rdy); end
        cyc();
        idle_req(); bus.man_rdt = 32'hBEEF0000; #1;
        n_chk++; if (bus.sub_rdt !== 32'h0000BEEF) begin n_fail++; $display("FAIL b2b_b_rdt got %h exp beef", bus.sub_rdt); end
        cyc(); bus.man_rdt = '0;
    endtask

    task automatic test_reset_mid();
        req(1'b0, 1'b0, 32'h103, 2'd2, 32'h0);
        cyc();
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_pre_busy got %b exp 1", busy); end
        rst = 1'b1; bus.man_rdt = 32'hAA000000; bus.man_err = 1'b1; #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy got %b exp 0", busy); end
        n_chk++; if (bus.man_ben !== 4'b1000) begin n_fail++; $display("FAIL rm_ben got %b exp 1000", bus.man_ben); end
        n_chk++; if (bus.sub_rdt !== 32'h0) begin n_fail++; $display("FAIL rm_rdt got %h exp 0", bus.sub_rdt); end
        n_chk++; if (bus.sub_err !== 1'b0) begin n_fail++; $display("FAIL rm_err got %b exp 0", bus.sub_err); end
        bus.sub_vld = 1'b0; #1;
        n_chk++; if (bus.man_vld !== 1'b0) begin n_fail++; $display("FAIL rm_vld_lo got %b exp 0", bus.man_vld); end
        bus.sub_vld = 1'b1; #1;
        n_chk++; if (bus.man_vld !== 1'b1) begin n_fail++; $display("FAIL rm_vld_hi got %b exp 1", bus.man_vld); end
        idle_req();
        cyc();
        rst = 1'b0;
        bus.man_rdt = 32'h00DDCCBB;
        cyc();
        n_chk++; if (bus.sub_rdt !== 32'h0) begin n_fail++; $display("FAIL rm_stale_rdt got %h exp 0", bus.sub_rdt); end
        n_chk++; if (bus.sub_err !== 1'b0) begin n_fail++; $display("FAIL rm_stale_err got %b exp 0", bus.sub_err); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_post_busy got %b exp 0", busy); end
        bus.man_rdt = '0; bus.man_err = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_split_write();
        test_split_read_stall();
        test_split_err();
        test_big_endian();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tcb_lib_misalign_splitter.md
Name: tcb_lib_misalign_splitter

Overview:
Converts REFERENCE-style TCB requests (byte address plus size) into MEMORY-mode requests (aligned address, byte enables, lane-placed data). Unlike the purely combinational converter, it does not flag misaligned accesses. It splits any access that crosses a data-bus boundary into two aligned beats, then reassembles the read data and error for the subordinate-side response. It sits between a CPU load/store unit and an aligned memory or interconnect.

Parameters:
ADR, 32, address width in bits.
DAT, 32, data width in bits; power of two, >= 16.
DLY, 1, fixed response delay of both ports in cycles; >= 1.
BEN, DAT/8, derived: byte lanes. OFW = log2(BEN) offset bits.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
sub_vld  input  1  request valid
sub_rdy  output  1  request ready
sub_wen  input  1  write enable
sub_ndn  input  1  0 = little-endian, 1 = big-endian
sub_adr  input  ADR  byte address
sub_siz  input  2  log2 of access bytes; must be <= OFW
sub_wdt  input  DAT  write data, right-justified
sub_rdt  output  DAT  read data, right-justified, DLY cycles after the final handshake
sub_err  output  1  response error
man_vld  output  1  request valid
man_rdy  input  1  request ready
man_wen  output  1  write enable
man_adr  output  ADR  aligned address; low OFW bits are zero
man_ben  output  BEN  byte enables
man_wdt  output  DAT  lane-placed write data
man_rdt  input  DAT  read data
man_err  input  1  response error
busy  output  1  FSM in SECOND state

Behaviour:
- Definitions: off = sub_adr[OFW-1:0]; n = 2**sub_siz; spl = (off + n > BEN); base = sub_adr with low OFW bits cleared.
- Access byte k (k = 0..n-1) maps to sub_wdt byte k when sub_ndn = 0, and to sub_wdt byte n-1-k when sub_ndn = 1. Byte k targets absolute lane (off + k) mod BEN.
- Unused man_wdt lanes are driven to 0.
- FSM states:
  - IDLE (reset state).
  - IDLE with !spl: single beat. man_vld = sub_vld; sub_rdy = man_rdy; man_adr = base; man_ben has bits off..off+n-1 set.
  - IDLE with spl: beat 0. man_vld = sub_vld; sub_rdy = 0; man_adr = base; man_ben has bits off..BEN-1 set. A man handshake moves the FSM to SECOND.
  - SECOND: beat 1. man_vld = 1; sub_rdy = man_rdy; man_adr = base + BEN (wraps modulo 2**ADR); man_ben has bits 0..off+n-BEN-1 set. A man handshake returns the FSM to IDLE.
- sub request fields must stay stable while sub_vld && !sub_rdy (TCB rule), so beat 1 is built from the live sub inputs.
- man_wen = sub_wen in all states.
- Response tracking:
  - A DLY-deep shift register records, per man handshake: {valid, kind (single / beat0 / beat1), off, siz, ndn}.
  - When a beat0 entry exits the register, man_rdt is latched into the hold register and man_err into the err-hold bit.
  - When a beat1 entry exits, sub_rdt is assembled from the hold register (lanes off..BEN-1) and the live man_rdt (lanes 0..), and sub_err = err-hold | man_err.
  - A single entry extracts lanes off..off+n-1 from man_rdt directly, and sub_err = man_err.
  - The extracted bytes are byte-reversed when ndn = 1, then zero-extended to DAT.
- Latency: the sub response appears DLY cycles after the sub handshake, for both split and unsplit accesses. Back-to-back requests are fully pipelined; the only stall is the extra beat on a split.
- Reset values: FSM IDLE, busy = 0, pipeline entries invalid, hold register 0, err-hold 0, sub_rdt = 0, sub_err = 0.
- Reset mid-operation: the FSM returns to IDLE and all in-flight responses are discarded.
- sub_siz > OFW is illegal; a simulation assertion fires on it.

Test Plan:
- DAT=32, DLY=1. Read word at adr 0x100, man_rdt = 0xDDCCBBAA -> one beat, man_ben = 4'b1111, sub_rdt = 0xDDCCBBAA one cycle later.
- Write word at 0x103, wdt 0x44332211, little-endian -> beat0: adr 0x100, ben 4'b1000, wdt 0x11000000. Beat1: adr 0x104, ben 4'b0111, wdt 0x00443322.
- Read word at 0x103, man_rdy low for 3 cycles between beats, beat0 rdt 0xAA000000, beat1 rdt 0x00DDCCBB -> sub_rdt 0xDDCCBBAA.
- Same read with beat0 man_err = 1 -> sub_err = 1.
- Big-endian halfword write at 0x3, wdt 0x1122 -> beat0: adr 0x0, ben 4'b1000, byte3 = 0x11. Beat1: adr 0x4, ben 4'b0001, byte0 = 0x22.
- Word read at 0xFFFFFFFE -> beat1 adr 0x00000000 (wraps).
- Assert rst while busy = 1 -> busy = 0, man_vld follows sub_vld in IDLE, and no stale response is produced.
